// File: rtl/timer_pkg.sv
// Shared definitions for the interval timer: bus map, TCON bit layout and reset values.
package timer_pkg;

    localparam logic [31:0] ADDR_TH   = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL   = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON = 32'h4000_0008;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;
    localparam int TCON_OS = 3;

    localparam logic [31:0] TH_RESET   = 32'h0000_0000;
    localparam logic [31:0] TL_RESET   = 32'h0000_0000;
    localparam logic [3:0]  TCON_RESET = 4'b0000;

    // Overflow is recognised on the all-ones value, not on a carry out.
    localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_TH,
        SEL_TL,
        SEL_TCON
    } reg_sel_e;

    function automatic reg_sel_e decode_addr(input logic [31:0] addr);
        reg_sel_e sel;
        case (addr)
            ADDR_TH:   sel = SEL_TH;
            ADDR_TL:   sel = SEL_TL;
            ADDR_TCON: sel = SEL_TCON;
            default:   sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Clock-enable generator: one-cycle tick every PRESCALE cycles while en is high.
module tick_prescaler
    import timer_pkg::*;
#(
    parameter logic [15:0] PRESCALE = 16'd5
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    logic [15:0] count;
    logic        at_end;

    assign at_end = (count == PRESCALE - 16'd1);

    // Counter parks at 0 whenever disabled so a re-enable always starts a full period.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (!en || at_end) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

    assign tick = en & at_end;

endmodule

// File: rtl/timer_ctrl.sv
// Memory-mapped interval timer: TH reload, TL up-counter and TCON control/status.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter logic [15:0] PRESCALE = 16'd5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tick,
    output logic        irq
);

    logic [31:0] th;
    logic [31:0] tl;
    logic [3:0]  tcon;
    logic [31:0] th_next;
    logic [31:0] tl_next;
    logic [3:0]  tcon_next;

    reg_sel_e sel;
    logic     wr_th;
    logic     wr_tl;
    logic     wr_tcon;
    logic     overflow;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .en   (tcon[TCON_EN]),
        .tick (tick)
    );

    assign sel      = decode_addr(addr);
    assign wr_th    = mem_write && (sel == SEL_TH);
    assign wr_tl    = mem_write && (sel == SEL_TL);
    assign wr_tcon  = mem_write && (sel == SEL_TCON);
    assign overflow = tick && (tl == TL_MAX);

    // Later assignments win: CPU TL write beats the count, overflow ST set beats a W1C clear.
    always_comb begin
        th_next   = th;
        tl_next   = tl;
        tcon_next = tcon;

        if (wr_th) begin
            th_next = wdata;
        end

        if (tick) begin
            tl_next = overflow ? th : tl + 32'd1;
        end
        if (wr_tl) begin
            tl_next = wdata;
        end

        if (wr_tcon) begin
            tcon_next[TCON_EN] = wdata[TCON_EN];
            tcon_next[TCON_IE] = wdata[TCON_IE];
            tcon_next[TCON_OS] = wdata[TCON_OS];
            if (wdata[TCON_ST]) begin
                tcon_next[TCON_ST] = 1'b0;
            end
        end

        if (overflow) begin
            if (tcon[TCON_IE]) begin
                tcon_next[TCON_ST] = 1'b1;
            end
            if (tcon[TCON_OS]) begin
                tcon_next[TCON_EN] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th   <= TH_RESET;
            tl   <= TL_RESET;
            tcon <= TCON_RESET;
        end else begin
            th   <= th_next;
            tl   <= tl_next;
            tcon <= tcon_next;
        end
    end

    // Reads show the pre-update register value and are zero unless strobed at a mapped address.
    always_comb begin
        rdata = 32'h0000_0000;
        if (mem_read) begin
            case (sel)
                SEL_TH:   rdata = th;
                SEL_TL:   rdata = tl;
                SEL_TCON: rdata = {28'h000_0000, tcon};
                default:  rdata = 32'h0000_0000;
            endcase
        end
    end

    assign irq = tcon[TCON_ST];

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl (PRESCALE=5 main instance, PRESCALE=1 side instance).
module tb_timer_ctrl;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_BAD  = 32'h4000_000C;

    logic        clk;
    logic        reset;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tick;
    logic        irq;
    logic [31:0] rdata1;
    logic        tick1;
    logic        irq1;

    int checks;
    int errors;
    logic [31:0] rd;
    logic [31:0] exp_tl;

    timer_ctrl #(.PRESCALE(16'd5)) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_write(mem_write),
        .mem_read (mem_read),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .tick     (tick),
        .irq      (irq)
    );

    timer_ctrl #(.PRESCALE(16'd1)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .mem_write(mem_write),
        .mem_read (mem_read),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata1),
        .tick     (tick1),
        .irq      (irq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        checks++;
        if (got !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
        mem_write = 1'b1;
        addr      = a;
        wdata     = d;
        step();
        mem_write = 1'b0;
    endtask

    task automatic readReg(input logic [31:0] a, output logic [31:0] d);
        mem_read = 1'b1;
        addr     = a;
        #1;
        d        = rdata;
        mem_read = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        addr      = '0;
        wdata     = '0;
        step();
        step();
        reset = 1'b0;
        step();

        $display("[TB] reset state");
        readReg(A_TH, rd);   checkOutput("reset_th", rd, 32'h0);
        readReg(A_TL, rd);   checkOutput("reset_tl", rd, 32'h0);
        readReg(A_TCON, rd); checkOutput("reset_tcon", rd, 32'h0);
        checkOutput("reset_tick", {31'b0, tick}, 32'h0);
        checkOutput("reset_irq", {31'b0, irq}, 32'h0);
        checkOutput("reset_tick1", {31'b0, tick1}, 32'h0);
        applyStimulus(A_BAD, 32'hDEAD_BEEF);
        readReg(A_BAD, rd);  checkOutput("unmapped_read", rd, 32'h0);
        readReg(A_TH, rd);   checkOutput("unmapped_write_th", rd, 32'h0);
        readReg(A_TL, rd);   checkOutput("unmapped_write_tl", rd, 32'h0);

        $display("[TB] periodic count and overflow");
        applyStimulus(A_TH, 32'hFFFF_FFFD);
        applyStimulus(A_TL, 32'hFFFF_FFFD);
        applyStimulus(A_TCON, 32'h0000_0003);
        mem_read = 1'b0;
        addr     = A_TCON;
        #1;
        checkOutput("no_strobe_read", rdata, 32'h0);
        for (int c = 1; c <= 16; c++) begin
            if (c <= 5)       exp_tl = 32'hFFFF_FFFD;
            else if (c <= 10) exp_tl = 32'hFFFF_FFFE;
            else if (c <= 15) exp_tl = 32'hFFFF_FFFF;
            else              exp_tl = 32'hFFFF_FFFD;
            checkOutput($sformatf("tick_c%0d", c), {31'b0, tick}, {31'b0, (c % 5) == 0});
            checkOutput($sformatf("tick1_c%0d", c), {31'b0, tick1}, 32'h1);
            checkOutput($sformatf("irq_c%0d", c), {31'b0, irq}, {31'b0, c == 16});
            readReg(A_TL, rd);
            checkOutput($sformatf("tl_c%0d", c), rd, exp_tl);
            if (c < 16) step();
        end

        $display("[TB] interrupt clear and clear-vs-overflow");
        applyStimulus(A_TCON, 32'h0000_0007);
        checkOutput("irq_cleared", {31'b0, irq}, 32'h0);
        step(); step(); step();
        checkOutput("tick_after_clear", {31'b0, tick}, 32'h1);
        step();
        readReg(A_TL, rd);   checkOutput("tl_counting", rd, 32'hFFFF_FFFE);
        for (int i = 0; i < 9; i++) step();
        checkOutput("tick_ovf2", {31'b0, tick}, 32'h1);
        readReg(A_TL, rd);   checkOutput("tl_before_ovf2", rd, 32'hFFFF_FFFF);
        applyStimulus(A_TCON, 32'h0000_0007);
        checkOutput("irq_clear_loses", {31'b0, irq}, 32'h1);
        readReg(A_TL, rd);   checkOutput("tl_reload2", rd, 32'hFFFF_FFFD);

        $display("[TB] one-shot");
        applyStimulus(A_TCON, 32'h0000_0004);
        checkOutput("irq_off_before_os", {31'b0, irq}, 32'h0);
        applyStimulus(A_TL, 32'hFFFF_FFFF);
        applyStimulus(A_TH, 32'h0000_0100);
        applyStimulus(A_TCON, 32'h0000_000B);
        for (int i = 1; i <= 5; i++) begin
            checkOutput($sformatf("os_tick_c%0d", i), {31'b0, tick}, {31'b0, i == 5});
            if (i < 5) step();
        end
        step();
        checkOutput("os_irq", {31'b0, irq}, 32'h1);
        readReg(A_TL, rd);   checkOutput("os_tl_reload", rd, 32'h0000_0100);
        readReg(A_TCON, rd); checkOutput("os_tcon", rd, 32'h0000_000E);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("os_no_tick_%0d", i), {31'b0, tick}, 32'h0);
            step();
        end
        readReg(A_TL, rd);   checkOutput("os_tl_hold", rd, 32'h0000_0100);

        $display("[TB] TL write in tick cycle");
        applyStimulus(A_TCON, 32'h0000_0007);
        checkOutput("irq_clear_os", {31'b0, irq}, 32'h0);
        step(); step(); step(); step();
        checkOutput("tick_tlw", {31'b0, tick}, 32'h1);
        applyStimulus(A_TL, 32'h1234_5678);
        readReg(A_TL, rd);   checkOutput("tl_write_wins", rd, 32'h1234_5678);

        $display("[TB] disable mid-period and re-enable");
        step(); step(); step();
        checkOutput("tick_mid", {31'b0, tick}, 32'h0);
        applyStimulus(A_TCON, 32'h0000_0002);
        checkOutput("tick_disabled_a", {31'b0, tick}, 32'h0);
        step();
        checkOutput("tick_disabled_b", {31'b0, tick}, 32'h0);
        readReg(A_TL, rd);   checkOutput("tl_disabled", rd, 32'h1234_5678);
        applyStimulus(A_TCON, 32'h0000_0003);
        for (int i = 1; i <= 5; i++) begin
            checkOutput($sformatf("reen_tick_c%0d", i), {31'b0, tick}, {31'b0, i == 5});
            if (i < 5) step();
        end
        step();
        readReg(A_TL, rd);   checkOutput("tl_after_reen", rd, 32'h1234_5679);

        $display("[TB] reset mid-count");
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        readReg(A_TH, rd);   checkOutput("mid_reset_th", rd, 32'h0);
        readReg(A_TL, rd);   checkOutput("mid_reset_tl", rd, 32'h0);
        readReg(A_TCON, rd); checkOutput("mid_reset_tcon", rd, 32'h0);
        checkOutput("mid_reset_irq", {31'b0, irq}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("mid_reset_tick_%0d", i), {31'b0, tick}, 32'h0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Memory-mapped interval timer controller for the pipelined CPU's peripheral bus. A programmable prescaler generates a single-cycle clock-enable `tick`. No derived clock is produced; every consumer stays on `clk`. On each tick a 32-bit up-counter advances, reloads from a period register on overflow, and raises a level interrupt to the CPU. The CPU configures, starts, stops and acknowledges the timer through three word registers.

## Interface
- `ADDR_TH`, 32'h4000_0000: address of reload register TH.
- `ADDR_TL`, 32'h4000_0004: address of counter register TL.
- `ADDR_TCON`, 32'h4000_0008: address of control/status register TCON.
- `PRESCALE`, 16'd5: `clk` cycles per tick. Legal range is 1..65535.

- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `mem_write`, in, 1: bus write strobe. Sampled at the rising edge of `clk`.
- `mem_read`, in, 1: bus read strobe.
- `addr`, in, 32: bus word address.
- `wdata`, in, 32: bus write data.
- `rdata`, out, 32: read data. Combinational.
- `tick`, out, 1: one-cycle enable pulse, once per prescale period, while the timer is enabled.
- `irq`, out, 1: interrupt request. Equals TCON[2].

## Operation
- TCON bits:
  - [0] EN: count enable.
  - [1] IE: interrupt enable.
  - [2] ST: interrupt status.
  - [3] OS: one-shot mode.
  - [31:4] read as 0.
- Reset: TH=0, TL=0, TCON=0, prescaler=0, `tick`=0, `irq`=0, `rdata`=0.
- Writes:
  - Write to TH loads `wdata`.
  - Write to TL loads `wdata`.
  - Write to TCON loads bits [0], [1] and [3].
  - Writing 1 to TCON[2] clears ST (write-1-to-clear). Writing 0 to TCON[2] leaves ST unchanged.
  - Writes to unmapped addresses are ignored.
- Reads: `rdata` = selected register when `mem_read` is high and the address matches, else 0. A read returns the current register value, before that cycle's update.
- Prescaler:
  - While EN=1, counts 0..PRESCALE-1 and wraps to 0.
  - `tick` = EN & (prescaler == PRESCALE-1).
  - While EN=0, the prescaler is held at 0.
- Counter: on `tick`:
  - If TL == 32'hFFFF_FFFF (overflow): TL <= TH. If IE=1, ST <= 1. If OS=1, EN <= 0.
  - Otherwise: TL <= TL + 1, with 32-bit wrap-free arithmetic. Overflow is detected on the all-ones value, never by carry.
- Simultaneous events:
  - A CPU write to TL in a tick cycle wins over the increment or reload.
  - A CPU write to TCON that clears ST in an overflow cycle loses: ST ends at 1, so no interrupt is lost.
  - A CPU write setting EN=0 in a tick cycle: the tick still updates TL, and the prescaler then clears.
  - A write to TH in an overflow cycle: the reload uses the old TH.
- Reset asserted mid-count returns everything to reset values at the next edge.

## Timing
- Register writes take effect at the rising edge that samples `mem_write`.
- After the edge that sets EN, the prescaler counts from 0. The first `tick` is high in the PRESCALE-th cycle after that edge.
- After the first tick, `tick` recurs every PRESCALE cycles.
- With PRESCALE=1, `tick` is high every cycle while EN=1.
- TL changes at the edge ending a tick cycle.
- `irq` rises one cycle after the overflow tick cycle. It stays high until cleared by software.
- Read path is zero latency: `rdata` is combinational from `addr`, `mem_read` and the register state.

## Structure
- Shared package `timer_pkg`:
  - Address constants.
  - TCON bit indices `TCON_EN`, `TCON_IE`, `TCON_ST`, `TCON_OS`.
  - Reset value constants.
- Sub-module `tick_prescaler`:
  - Ports: `clk`, `reset`, `en`, `tick`.
  - Parameter: `PRESCALE`.
  - Synchronous-reset clock-enable generator.
- `timer_ctrl` holds the TH/TL/TCON registers, the bus decode and the overflow/priority logic.

## Test plan
- Reset, then read all three addresses -> `rdata`=0 each time; `tick`=0 and `irq`=0 throughout.
- Write TH=TL=32'hFFFF_FFFD, then TCON=4'b0011 with PRESCALE=5 -> ticks every 5 cycles; TL goes FFFF_FFFE, FFFF_FFFF, then FFFF_FFFD on the 3rd tick (cycle 15); `irq`=1 one cycle later.
- With `irq` high, write TCON=4'b0111 -> `irq`=0 next cycle while counting continues. Repeat the clear in the exact overflow cycle -> `irq` stays 1.
- One-shot: TL=32'hFFFF_FFFF, TCON=4'b1011 -> a single overflow sets ST and clears EN; no further ticks; TL holds TH.
- Write TL=32'h1234_5678 in a tick cycle -> TL reads 32'h1234_5678 afterwards, not an incremented value.
- Disable mid-period (prescaler at 3) and re-enable -> the next tick occurs exactly PRESCALE cycles after re-enable. Assert `reset` mid-count -> all registers read 0.
